// File: rtl/cache_line_server_if.sv
// Memory-side command/response port of cache_line_server.
//
// Carries an in-order halfword command channel (valid/ready handshake with
// write flag, halfword address and write data) and the read-return channel
// (rvalid/rdata, returned in command order, never back-pressured).
//
// Modports:
//   master - the line server: drives commands, receives ready and returns.
//   slave  - the SDRAM/SRAM backend: accepts commands, drives returns.
`timescale 1ns/1ps
interface cache_line_server_if #(
  parameter int ADDR = 21
);
  logic            mem_cmd_valid;
  logic            mem_cmd_ready;
  logic            mem_cmd_we;
  logic [ADDR-2:0] mem_cmd_addr;
  logic [15:0]     mem_cmd_wdata;
  logic            mem_rvalid;
  logic [15:0]     mem_rdata;

  modport master (
    output mem_cmd_valid,
    output mem_cmd_we,
    output mem_cmd_addr,
    output mem_cmd_wdata,
    input  mem_cmd_ready,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_cmd_valid,
    input  mem_cmd_we,
    input  mem_cmd_addr,
    input  mem_cmd_wdata,
    output mem_cmd_ready,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/cache_line_server.sv
// cache_line_server: memory-side responder for the cache controller's
// line-transfer interface. Each level request moves exactly one line of
// 2^(LINE-1) halfwords between the cache and an in-order memory port.
//
//   fill       (ddr_rd): read commands {base,k}, each return is registered
//                        onto ddr_din and strobed with cache_write_data.
//   write-back (ddr_wr): cache_read_data strobes pull halfwords out of the
//                        cache; they arrive RD_LAT clocks later on ddr_dout,
//                        are staged in a small FIFO and issued as writes.
//
// Ports:
//   clk, rst_n        memory clock, synchronous active-low reset
//   ddr_rd, ddr_wr    fill / write-back requests (level, sampled in IDLE)
//   hiaddr            line address, latched as base at burst start
//   ddr_dout          halfword read from the cache
//   ddr_din           halfword written into the cache
//   cache_write_data  cache captures ddr_din this edge
//   cache_read_data   cache presents the next halfword
//   mem               memory command/return port (master side)
//   busy              high whenever the FSM is not IDLE
`timescale 1ns/1ps
module cache_line_server #(
  parameter int ADDR       = 21,
  parameter int LINE       = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ddr_rd,
  input  logic                 ddr_wr,
  input  logic [ADDR-LINE-1:0] hiaddr,
  input  logic [15:0]          ddr_dout,
  output logic [15:0]          ddr_din,
  output logic                 cache_write_data,
  output logic                 cache_read_data,
  cache_line_server_if.master  mem,
  output logic                 busy
);

  localparam int WORDS = 1 << (LINE - 1);
  localparam int KW    = LINE - 1;
  localparam int CW    = LINE;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW    = PW + 1;

  typedef enum logic [1:0] {IDLE, WB, FILL, GAP} state_t;

  state_t               state;
  logic [ADDR-LINE-1:0] base;
  logic [CW-1:0]        cmd_cnt;    // commands accepted in this burst
  logic [CW-1:0]        strb_cnt;   // cache strobes issued in this burst
  logic [15:0]          fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [OW-1:0]        occ;
  logic [RD_LAT-1:0]    vld_p;      // bit i: a read strobe issued i+1 clocks ago

  logic                 cmd_fire;
  logic                 push;
  logic                 pop;
  logic [OW-1:0]        occ_nxt;
  logic [RD_LAT-1:0]    vld_p_nxt;
  logic [CW-1:0]        strb_cnt_nxt;
  logic                 credit_nxt;

  function automatic logic [7:0] ones(input logic [RD_LAT-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < RD_LAT; i++) n = n + 8'(v[i]);
    return n;
  endfunction

  // Memory command port: fill reads walk cmd_cnt, write-backs drain the FIFO.
  // Valid depends only on registered state, so it cannot drop before the
  // handshake, and addr/data only move when cmd_cnt/rd_ptr move on a fire.
  assign mem.mem_cmd_valid = ((state == FILL) && (cmd_cnt < CW'(WORDS))) ||
                             ((state == WB) && (occ != '0));
  assign mem.mem_cmd_we    = (state == WB) && (occ != '0);
  assign mem.mem_cmd_addr  = mem.mem_cmd_valid ? {base, cmd_cnt[KW-1:0]} : '0;
  assign mem.mem_cmd_wdata = mem.mem_cmd_we ? fifo_mem[rd_ptr] : '0;
  assign busy              = (state != IDLE);

  // Next-cycle write-back bookkeeping. The strobe register is loaded from
  // post-update occupancy and pipe contents, so a strobe in a cycle is backed
  // by a credit counted against that cycle's own occupancy; a pop made this
  // cycle frees its slot for the next one.
  always_comb begin
    cmd_fire     = mem.mem_cmd_valid & mem.mem_cmd_ready;
    push         = (state == WB) & vld_p[RD_LAT-1];
    pop          = (state == WB) & cmd_fire;
    occ_nxt      = occ + OW'(push) - OW'(pop);
    vld_p_nxt    = (vld_p << 1) | RD_LAT'(cache_read_data);
    strb_cnt_nxt = strb_cnt + CW'(cache_read_data);
    credit_nxt   = (strb_cnt_nxt < CW'(WORDS)) &&
                   ((8'(occ_nxt) + ones(vld_p_nxt)) < 8'(FIFO_DEPTH));
  end

  // Stage: FIFO storage, written when a halfword leaves the latency pipe.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ddr_dout;
  end

  // Stage: control FSM with registered strobes and fill return data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      base             <= '0;
      cmd_cnt          <= '0;
      strb_cnt         <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      occ              <= '0;
      vld_p            <= '0;
      ddr_din          <= '0;
      cache_write_data <= 1'b0;
      cache_read_data  <= 1'b0;
    end else begin
      cache_write_data <= 1'b0;
      cache_read_data  <= 1'b0;
      case (state)
        IDLE: begin
          if (ddr_wr) begin
            base            <= hiaddr;
            state           <= WB;
            // Empty FIFO and pipe: the first halfword can be requested at once.
            cache_read_data <= 1'b1;
          end else if (ddr_rd) begin
            base  <= hiaddr;
            state <= FILL;
          end
        end

        FILL: begin
          if (cmd_fire) cmd_cnt <= cmd_cnt + CW'(1);
          // One cache strobe per return, capped at a line so the controller's
          // counter wraps exactly once.
          if (mem.mem_rvalid && (strb_cnt < CW'(WORDS))) begin
            ddr_din          <= mem.mem_rdata;
            cache_write_data <= 1'b1;
            strb_cnt         <= strb_cnt + CW'(1);
          end
          // strb_cnt reaches WORDS together with the last strobe; leave once
          // that strobe has been presented.
          if (strb_cnt == CW'(WORDS)) state <= GAP;
        end

        WB: begin
          cache_read_data <= credit_nxt;
          strb_cnt        <= strb_cnt_nxt;
          vld_p           <= vld_p_nxt;
          occ             <= occ_nxt;
          if (push) wr_ptr <= wr_ptr + PW'(1);
          if (pop) begin
            rd_ptr  <= rd_ptr + PW'(1);
            cmd_cnt <= cmd_cnt + CW'(1);
            if (cmd_cnt == CW'(WORDS - 1)) state <= GAP;
          end
        end

        GAP: begin
          // Quiet cycle so IDLE sees fresh request lines and hiaddr.
          cmd_cnt  <= '0;
          strb_cnt <= '0;
          wr_ptr   <= '0;
          rd_ptr   <= '0;
          occ      <= '0;
          vld_p    <= '0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_server.sv
// Testbench for cache_line_server: directed bursts against a behavioural
// backend (in-order reads returning addr[15:0] three clocks after the
// command) and a cache model (halfword k of a write-back line is A000+k,
// valid RD_LAT clocks after its strobe). Expected command streams are queued
// per burst; one negedge process compares the DUT against them every cycle.
`timescale 1ns/1ps
module tb_cache_line_server;
  localparam int ADDR = 21, LINE = 6, FIFO_DEPTH = 4, RD_LAT = 2;
  localparam int AW = ADDR - 1, HW = ADDR - LINE;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ddr_rd = 1'b0, ddr_wr = 1'b0;
  logic [HW-1:0] hiaddr = '0;
  logic [15:0]   ddr_dout = 16'hDEAD;
  logic [15:0]   ddr_din;
  logic          cache_write_data, cache_read_data, busy;

  cache_line_server_if #(.ADDR(ADDR)) mem_if ();

  cache_line_server #(.ADDR(ADDR), .LINE(LINE), .FIFO_DEPTH(FIFO_DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .ddr_rd(ddr_rd), .ddr_wr(ddr_wr), .hiaddr(hiaddr),
    .ddr_dout(ddr_dout), .ddr_din(ddr_din), .cache_write_data(cache_write_data),
    .cache_read_data(cache_read_data), .mem(mem_if), .busy(busy));

  always #5 clk = ~clk;

  typedef struct { logic we; logic [AW-1:0] addr; logic [15:0] data; } cmd_t;
  typedef struct { int due; logic [15:0] data; } ret_t;

  int tests = 0, fails = 0;
  cmd_t exp_q[$];
  ret_t ret_q[$];
  int cyc = 0;
  int rd_strobes = 0, wr_strobes = 0, wr_acc = 0, rd_acc = 0;
  int last_wr_cyc = 0, first_rd_cyc = -1;
  logic stall = 1'b0, stray = 1'b0;
  logic exp_cwd = 1'b0;
  logic [15:0] exp_din = '0, last_din = '0, last_wdata = '0;
  logic [AW-1:0] first_addr = '0, last_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_counts();
    rd_strobes = 0; wr_strobes = 0; wr_acc = 0; rd_acc = 0;
  endtask

  task automatic queue_fill(input logic [HW-1:0] b);
    cmd_t c;
    for (int k = 0; k < 32; k++) begin
      c.we = 1'b0; c.addr = {b, 5'(k)}; c.data = 16'h0;
      exp_q.push_back(c);
    end
  endtask

  task automatic queue_wb(input logic [HW-1:0] b);
    cmd_t c;
    for (int k = 0; k < 32; k++) begin
      c.we = 1'b1; c.addr = {b, 5'(k)}; c.data = 16'hA000 + 16'(k);
      exp_q.push_back(c);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin tick(); n++; end
    check({name, "_done"}, 32'(n < 2000), 32'd1);
  endtask

  // Compare / environment process: samples mid-cycle, drives backend and cache.
  initial begin : env
    int h1, h2;
    cmd_t c;
    ret_t r;
    h1 = -1; h2 = -1;
    mem_if.mem_cmd_ready = 1'b0;
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      // fill strobes toward the cache
      check("cwd_strobe", 32'(cache_write_data), 32'(exp_cwd));
      if (exp_cwd) check("ddr_din", 32'(ddr_din), 32'(exp_din));
      if (cache_write_data) begin wr_strobes++; last_din = ddr_din; end
      // write-back strobes: never more than a line, never beyond FIFO credit
      if (cache_read_data) begin
        rd_strobes++;
        check("crd_credit", 32'((rd_strobes - wr_acc) <= FIFO_DEPTH && rd_strobes <= 32), 32'd1);
      end
      if (!rst_n) begin h1 = -1; h2 = -1; end
      ddr_dout = (h2 >= 0) ? (16'hA000 + 16'(h2)) : 16'hDEAD;
      h2 = h1;
      h1 = cache_read_data ? (rd_strobes - 1) : -1;
      // memory command side
      mem_if.mem_cmd_ready = rst_n && !stall;
      if (mem_if.mem_cmd_valid && mem_if.mem_cmd_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL cmd_extra: got addr %h we %b, required no command", mem_if.mem_cmd_addr, mem_if.mem_cmd_we);
        end else begin
          c = exp_q.pop_front();
          check("cmd_we", 32'(mem_if.mem_cmd_we), 32'(c.we));
          check("cmd_addr", 32'(mem_if.mem_cmd_addr), 32'(c.addr));
          if (c.we) check("cmd_wdata", 32'(mem_if.mem_cmd_wdata), 32'(c.data));
        end
        last_addr = mem_if.mem_cmd_addr;
        if (mem_if.mem_cmd_we) begin
          wr_acc++; last_wr_cyc = cyc; last_wdata = mem_if.mem_cmd_wdata;
        end else begin
          rd_acc++;
          if (rd_acc == 1) first_addr = mem_if.mem_cmd_addr;
          if (first_rd_cyc < 0) first_rd_cyc = cyc;
          r.due = cyc + 3; r.data = mem_if.mem_cmd_addr[15:0];
          ret_q.push_back(r);
        end
      end
      // read returns
      if (!rst_n) ret_q.delete();
      if (ret_q.size() != 0 && ret_q[0].due == cyc) begin
        r = ret_q.pop_front();
        mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = r.data;
        exp_cwd = 1'b1; exp_din = r.data;
      end else if (stray) begin
        mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 16'hBEEF;
        exp_cwd = 1'b0;
      end else begin
        mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = '0;
        exp_cwd = 1'b0;
      end
    end
  end

  initial begin : main
    int n;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_cwd", 32'(cache_write_data), 0);
    check("rst_crd", 32'(cache_read_data), 0);
    check("rst_valid", 32'(mem_if.mem_cmd_valid), 0);
    check("rst_we", 32'(mem_if.mem_cmd_we), 0);
    check("rst_addr", 32'(mem_if.mem_cmd_addr), 0);
    check("rst_wdata", 32'(mem_if.mem_cmd_wdata), 0);
    check("rst_din", 32'(ddr_din), 0);
    rst_n = 1'b1;
    tick();

    // fill at line 0x0123
    clear_counts(); queue_fill(15'h0123);
    hiaddr = 15'h0123; ddr_rd = 1'b1; tick();
    check("fill_busy", 32'(busy), 1);
    ddr_rd = 1'b0;
    wait_done("fill");
    check("fill_strobes", 32'(wr_strobes), 32);
    check("fill_reads", 32'(rd_acc), 32);
    check("fill_first_addr", 32'(first_addr), 32'h02460);
    check("fill_last_addr", 32'(last_addr), 32'h0247F);
    check("fill_last_din", 32'(last_din), 32'h247F);
    check("fill_no_crd", 32'(rd_strobes), 0);

    // write-back at line 0x0200
    clear_counts(); queue_wb(15'h0200);
    hiaddr = 15'h0200; ddr_wr = 1'b1; tick();
    ddr_wr = 1'b0;
    wait_done("wb");
    check("wb_strobes", 32'(rd_strobes), 32);
    check("wb_writes", 32'(wr_acc), 32);
    check("wb_last_addr", 32'(last_addr), 32'h0401F);
    check("wb_last_wdata", 32'(last_wdata), 32'hA01F);
    check("wb_no_cwd", 32'(wr_strobes), 0);

    // write-back with the backend stalled for 20 cycles
    clear_counts(); queue_wb(15'h0311);
    stall = 1'b1; hiaddr = 15'h0311; ddr_wr = 1'b1; tick();
    ddr_wr = 1'b0;
    repeat (19) tick();
    check("stall_strobes", 32'(rd_strobes), 4);
    check("stall_writes", 32'(wr_acc), 0);
    stall = 1'b0;
    wait_done("stall");
    check("stall_total_strobes", 32'(rd_strobes), 32);
    check("stall_total_writes", 32'(wr_acc), 32);
    check("stall_last_wdata", 32'(last_wdata), 32'hA01F);

    // both requests: write-back wins, fill follows at the new address
    clear_counts(); queue_wb(15'h0300); queue_fill(15'h0456);
    hiaddr = 15'h0300; ddr_wr = 1'b1; ddr_rd = 1'b1; first_rd_cyc = -1; tick();
    n = 0;
    while (rd_strobes < 16 && n < 500) begin tick(); n++; end
    check("prio_wait16", 32'(n < 500), 1);
    ddr_wr = 1'b0; hiaddr = 15'h0456;
    n = 0;
    while (rd_acc == 0 && n < 500) begin tick(); n++; end
    check("prio_fill_start", 32'(n < 500), 1);
    ddr_rd = 1'b0;
    wait_done("prio");
    check("prio_wb_writes", 32'(wr_acc), 32);
    check("prio_crd", 32'(rd_strobes), 32);
    check("prio_fill_reads", 32'(rd_acc), 32);
    check("prio_cwd", 32'(wr_strobes), 32);
    check("prio_gap", 32'(first_rd_cyc - last_wr_cyc), 3);
    check("prio_fill_addr", 32'(first_addr), 32'h08AC0);

    // reset in the middle of a fill
    clear_counts(); queue_fill(15'h0077);
    hiaddr = 15'h0077; ddr_rd = 1'b1; tick();
    ddr_rd = 1'b0;
    n = 0;
    while (wr_strobes < 10 && n < 500) begin tick(); n++; end
    check("abort_wait10", 32'(n < 500), 1);
    rst_n = 1'b0; tick();
    check("abort_busy", 32'(busy), 0);
    check("abort_cwd", 32'(cache_write_data), 0);
    check("abort_valid", 32'(mem_if.mem_cmd_valid), 0);
    check("abort_din", 32'(ddr_din), 0);
    rst_n = 1'b1; exp_q.delete();
    repeat (5) tick();
    check("abort_idle", 32'(busy), 0);
    clear_counts(); queue_fill(15'h0077);
    ddr_rd = 1'b1; tick();
    ddr_rd = 1'b0;
    wait_done("refill");
    check("refill_strobes", 32'(wr_strobes), 32);
    check("refill_reads", 32'(rd_acc), 32);
    check("refill_first_addr", 32'(first_addr), 32'h00EE0);

    // stray return while idle
    clear_counts();
    stray = 1'b1; tick();
    stray = 1'b0;
    repeat (3) tick();
    check("stray_cwd", 32'(wr_strobes), 0);
    check("stray_busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
